// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_unit                                                     |
// |   MIPS IF stage: req/ack fetch, output buffer + skid, stall/redirect flush |
// |   Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_incr4_IF,
  output logic [31:0] inst_IF,
  output logic        valid_IF
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_REQ     = 2'd1,
    S_BLOCKED = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_imem_req, w_imem_req_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic [31:0] r_pending_pc, w_pending_pc_nxt;
  logic        r_ob_valid, w_ob_valid_nxt;
  logic [31:0] r_ob_inst, w_ob_inst_nxt;
  logic [31:0] r_ob_pc4, w_ob_pc4_nxt;
  logic        r_sk_valid, w_sk_valid_nxt;
  logic [31:0] r_sk_inst, w_sk_inst_nxt;
  logic [31:0] r_sk_pc4, w_sk_pc4_nxt;

  logic        w_ack_req;
  logic        w_ack_any;
  logic        w_ob_take;
  logic [31:0] w_fetch_pc4;

  assign w_ack_req   = imem_ack && (r_state == S_REQ);
  assign w_ack_any   = imem_ack && ((r_state == S_REQ) || (r_state == S_DISCARD));
  // OB accepts new content when it is empty or is being consumed this edge.
  assign w_ob_take   = !r_ob_valid || !stall;
  assign w_fetch_pc4 = r_req_addr + 32'd4;

  always_comb begin
    w_state_nxt      = r_state;
    w_req_addr_nxt   = r_req_addr;
    w_pending_pc_nxt = r_pending_pc;
    w_ob_valid_nxt   = r_ob_valid;
    w_ob_inst_nxt    = r_ob_inst;
    w_ob_pc4_nxt     = r_ob_pc4;
    w_sk_valid_nxt   = r_sk_valid;
    w_sk_inst_nxt    = r_sk_inst;
    w_sk_pc4_nxt     = r_sk_pc4;

    if (redirect_valid) begin
      w_ob_valid_nxt = 1'b0;
      w_ob_inst_nxt  = 32'd0;
      w_ob_pc4_nxt   = 32'd0;
      w_sk_valid_nxt = 1'b0;
      w_sk_inst_nxt  = 32'd0;
      w_sk_pc4_nxt   = 32'd0;
      if ((r_state == S_BOOT) || (r_state == S_BLOCKED) || w_ack_any) begin
        w_req_addr_nxt = redirect_pc;
        w_state_nxt    = S_REQ;
      end else begin
        // Request still in flight: keep the address stable and drop its data later.
        w_pending_pc_nxt = redirect_pc;
        w_state_nxt      = S_DISCARD;
      end
    end else begin
      // SK is only ever full in BLOCKED, so an ack never competes with an SK drain.
      if (w_ob_take) begin
        if (r_sk_valid) begin
          w_ob_valid_nxt = 1'b1;
          w_ob_inst_nxt  = r_sk_inst;
          w_ob_pc4_nxt   = r_sk_pc4;
          w_sk_valid_nxt = 1'b0;
        end else if (w_ack_req) begin
          w_ob_valid_nxt = 1'b1;
          w_ob_inst_nxt  = imem_rdata;
          w_ob_pc4_nxt   = w_fetch_pc4;
        end else begin
          w_ob_valid_nxt = 1'b0;
          w_ob_inst_nxt  = 32'd0;
          w_ob_pc4_nxt   = 32'd0;
        end
      end else if (w_ack_req) begin
        w_sk_valid_nxt = 1'b1;
        w_sk_inst_nxt  = imem_rdata;
        w_sk_pc4_nxt   = w_fetch_pc4;
      end

      case (r_state)
        S_BOOT: begin
          w_req_addr_nxt = RESET_PC;
          w_state_nxt    = S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            w_req_addr_nxt = w_fetch_pc4;
            w_state_nxt    = w_sk_valid_nxt ? S_BLOCKED : S_REQ;
          end
        end
        S_BLOCKED: begin
          if (!w_sk_valid_nxt) w_state_nxt = S_REQ;
        end
        S_DISCARD: begin
          if (imem_ack) begin
            w_req_addr_nxt = r_pending_pc;
            w_state_nxt    = S_REQ;
          end
        end
        default: w_state_nxt = S_BOOT;
      endcase
    end

    w_imem_req_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_DISCARD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_imem_req   <= 1'b0;
      r_req_addr   <= 32'd0;
      r_pending_pc <= 32'd0;
      r_ob_valid   <= 1'b0;
      r_ob_inst    <= 32'd0;
      r_ob_pc4     <= 32'd0;
      r_sk_valid   <= 1'b0;
      r_sk_inst    <= 32'd0;
      r_sk_pc4     <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_imem_req   <= w_imem_req_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_pending_pc <= w_pending_pc_nxt;
      r_ob_valid   <= w_ob_valid_nxt;
      r_ob_inst    <= w_ob_inst_nxt;
      r_ob_pc4     <= w_ob_pc4_nxt;
      r_sk_valid   <= w_sk_valid_nxt;
      r_sk_inst    <= w_sk_inst_nxt;
      r_sk_pc4     <= w_sk_pc4_nxt;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_req_addr;
  assign inst_IF     = r_ob_inst;
  assign pc_incr4_IF = r_ob_pc4;
  assign valid_IF    = r_ob_valid;

endmodule
`default_nettype wire
